// File: rtl/run_sequencer_if.sv
// Control/status bundle between the run sequencer and whatever drives it (top level or bench).
// The sequencer takes the slave modport; the run requester takes the master modport.
interface run_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             launch;
   logic             halt;
   logic             abort;
   logic             proc_reset;
   logic             proc_start;
   logic             running;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;
   logic [2:0]       state;

   modport master (
      output launch, halt, abort,
      input  proc_reset, proc_start, running, done, timeout, cycle_count, state
   );

   modport slave (
      input  launch, halt, abort,
      output proc_reset, proc_start, running, done, timeout, cycle_count, state
   );
endinterface

// File: rtl/run_sequencer.sv
// Processor run controller: reset-then-start launch sequence, then run supervision with a
// saturating cycle counter, halt detection, abort and an optional watchdog.
module run_sequencer #(
   parameter int RESET_CYCLES = 2,
   parameter int START_CYCLES = 1,
   parameter int CNT_W        = 16,
   parameter int TIMEOUT      = 4096
) (
   input logic               clk,
   input logic               reset,
   run_sequencer_if.slave    bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RST   = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4,
      ST_TOUT  = 3'd5
   } state_t;

   localparam int PH_MAX = (RESET_CYCLES > START_CYCLES) ? RESET_CYCLES : START_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX) + 1;

   localparam logic [PH_W-1:0]  RST_LAST   = PH_W'(RESET_CYCLES - 1);
   localparam logic [PH_W-1:0]  START_LAST = PH_W'(START_CYCLES - 1);
   localparam logic [CNT_W-1:0] TOUT_LAST  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   state_t           state_r, state_s;
   logic [PH_W-1:0]  phase_r, phase_s;
   logic [CNT_W-1:0] count_r, count_s;
   logic             done_r, done_s;
   logic             timeout_r, timeout_s;
   logic             proc_reset_r, proc_start_r, running_r;

   // Next-state, phase counter, run counter and sticky flag logic.
   always_comb begin
      state_s   = state_r;
      phase_s   = phase_r;
      count_s   = count_r;
      done_s    = done_r;
      timeout_s = timeout_r;
      case (state_r)
         ST_IDLE: begin
            // abort in IDLE masks launch for that cycle
            if (bus.launch && !bus.abort) begin
               state_s   = ST_RST;
               phase_s   = '0;
               count_s   = '0;
               done_s    = 1'b0;
               timeout_s = 1'b0;
            end else begin
               phase_s = '0;
            end
         end
         ST_RST: begin
            if (bus.abort) begin
               state_s = ST_IDLE;
               phase_s = '0;
            end else if (phase_r == RST_LAST) begin
               state_s = ST_START;
               phase_s = '0;
            end else begin
               phase_s = phase_r + 1'b1;
            end
         end
         ST_START: begin
            if (bus.abort) begin
               state_s = ST_IDLE;
               phase_s = '0;
            end else if (phase_r == START_LAST) begin
               state_s = ST_RUN;
               phase_s = '0;
            end else begin
               phase_s = phase_r + 1'b1;
            end
         end
         ST_RUN: begin
            // Counter advances only on cycles that stay in RUN, so it reads the RUN cycles
            // completed before the exit edge.
            if (bus.abort) begin
               state_s = ST_IDLE;
            end else if (bus.halt) begin
               state_s = ST_DONE;
               done_s  = 1'b1;
            end else if ((TIMEOUT != 0) && (count_r == TOUT_LAST)) begin
               state_s   = ST_TOUT;
               timeout_s = 1'b1;
            end else if (count_r != CNT_MAX) begin
               count_s = count_r + 1'b1;
            end else begin
               count_s = count_r;
            end
         end
         ST_DONE, ST_TOUT: begin
            if (bus.abort) begin
               state_s   = ST_IDLE;
               done_s    = 1'b0;
               timeout_s = 1'b0;
            end else if (bus.launch) begin
               state_s   = ST_RST;
               phase_s   = '0;
               count_s   = '0;
               done_s    = 1'b0;
               timeout_s = 1'b0;
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
            phase_s = '0;
         end
      endcase
   end

   // State and output registers; outputs are decoded from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         phase_r      <= '0;
         count_r      <= '0;
         done_r       <= 1'b0;
         timeout_r    <= 1'b0;
         proc_reset_r <= 1'b1;
         proc_start_r <= 1'b0;
         running_r    <= 1'b0;
      end else begin
         state_r      <= state_s;
         phase_r      <= phase_s;
         count_r      <= count_s;
         done_r       <= done_s;
         timeout_r    <= timeout_s;
         proc_reset_r <= (state_s == ST_IDLE) || (state_s == ST_RST);
         proc_start_r <= (state_s == ST_START);
         running_r    <= (state_s == ST_RUN);
      end
   end

   assign bus.proc_reset  = proc_reset_r;
   assign bus.proc_start  = proc_start_r;
   assign bus.running     = running_r;
   assign bus.done        = done_r;
   assign bus.timeout     = timeout_r;
   assign bus.cycle_count = count_r;
   assign bus.state       = state_r;

endmodule
